// File: rtl/heap_level_ram_pkg.sv
// Shared heapsort definitions: empty-node sentinel,
// level sizing helpers and init sequencer states.
package heap_level_ram_pkg;

  localparam logic [63:0] HEAP_EMPTY = '1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } init_state_e;

  function automatic int level_depth(input int level);
    return 1 << level;
  endfunction

  function automatic int level_aw(input int level);
    return (level > 0) ? level : 1;
  endfunction

endpackage

// File: rtl/heap_level_ram_core.sv
// Bare true-dual-port level array, port A wins on
// same-address writes, optional registered read.
module heap_level_ram_core
  import heap_level_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int LEVEL        = 1,
  parameter int READ_LATENCY = 0,
  parameter int AW           = level_aw(LEVEL)
) (
  input  logic                  clk,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] clr_data_i,
  input  logic                  we_a_i,
  input  logic [AW-1:0]         addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  output logic [DATA_WIDTH-1:0] q_a_o,
  input  logic                  we_b_i,
  input  logic [AW-1:0]         addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  output logic [DATA_WIDTH-1:0] q_b_o
);

  localparam int    DEPTH     = level_depth(LEVEL);
  localparam string RAM_STYLE =
    (DEPTH >= 64) ? "block" : "distributed";

  (* ram_style = RAM_STYLE *)
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  // B first so a same-address A write overrides it
  always_ff @(posedge clk) begin
    if (we_b_i) ram_q[addr_b_i] <= data_b_i;
    if (we_a_i) ram_q[addr_a_i] <= data_a_i;
  end

  if (READ_LATENCY == 0) begin : g_comb
    logic unused_clr;
    assign unused_clr = clr_i ^ (^clr_data_i);
    assign q_a_o = ram_q[addr_a_i];
    assign q_b_o = ram_q[addr_b_i];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] qa_q;
    logic [DATA_WIDTH-1:0] qb_q;
    always_ff @(posedge clk) begin
      if (clr_i) begin
        qa_q <= clr_data_i;
        qb_q <= clr_data_i;
      end else begin
        qa_q <= ram_q[addr_a_i];
        qb_q <= ram_q[addr_b_i];
      end
    end
    assign q_a_o = qa_q;
    assign q_b_o = qb_q;
  end

endmodule

// File: rtl/heap_level_ram.sv
// Heap level storage with sentinel fill sequencer,
// busy masking and registered write-collision flag.
module heap_level_ram
  import heap_level_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int LEVEL        = 1,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE =
    HEAP_EMPTY[DATA_WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  collision
);

  localparam int AW    = level_aw(LEVEL);
  localparam int DEPTH = level_depth(LEVEL);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  init_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic coll_q, coll_d;
  logic busy;

  logic [AW-1:0] ia, ib;
  logic unused_addr;
  assign unused_addr = ^{addr_a, addr_b};

  if (LEVEL == 0) begin : g_l0
    assign ia = '0;
    assign ib = '0;
  end else begin : g_ln
    assign ia = addr_a[AW-1:0];
    assign ib = addr_b[AW-1:0];
  end

  assign busy = (state_q == FILL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (init_req) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = FILL;
    endcase
  end

  assign coll_d = !busy && !rst && we_a && we_b && (ia == ib);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
    end
  end

  // The fill owns port A; port B is silenced while busy
  logic                  cwe_a, cwe_b;
  logic [AW-1:0]         caddr_a;
  logic [DATA_WIDTH-1:0] cdata_a;
  logic [DATA_WIDTH-1:0] cq_a, cq_b;

  assign cwe_a   = busy || (we_a && !rst);
  assign caddr_a = busy ? cnt_q : ia;
  assign cdata_a = busy ? INIT_VALUE : data_a;
  assign cwe_b   = !busy && !rst && we_b;

  heap_level_ram_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LEVEL        (LEVEL),
    .READ_LATENCY (READ_LATENCY),
    .AW           (AW)
  ) u_core (
    .clk        (clk),
    .clr_i      (rst || busy),
    .clr_data_i (INIT_VALUE),
    .we_a_i     (cwe_a),
    .addr_a_i   (caddr_a),
    .data_a_i   (cdata_a),
    .q_a_o      (cq_a),
    .we_b_i     (cwe_b),
    .addr_b_i   (ib),
    .data_b_i   (data_b),
    .q_b_o      (cq_b)
  );

  assign init_busy = busy;
  assign q_a       = busy ? INIT_VALUE : cq_a;
  assign q_b       = busy ? INIT_VALUE : cq_b;
  assign collision = coll_q;

endmodule

// File: tb/tb_heap_level_ram.sv
// Directed bench: LEVEL=3 comb and registered reads,
// plus a LEVEL=0 single-word instance.
module tb_heap_level_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_req = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [4:0]  addr_a = '0, addr_b = '0;

  logic [31:0] q_a3, q_b3, q_a3r, q_b3r, q_a0, q_b0;
  logic        busy3, busy3r, busy0;
  logic        col3, col3r, col0;

  int n_cmp = 0;
  int n_err = 0;
  int c;

  always #5 clk = ~clk;

  heap_level_ram #(.LEVEL(3), .READ_LATENCY(0)) u_l3 (
    .clk(clk), .rst(rst), .init_req(init_req),
    .init_busy(busy3),
    .data_a(data_a), .we_a(we_a), .addr_a(addr_a), .q_a(q_a3),
    .data_b(data_b), .we_b(we_b), .addr_b(addr_b), .q_b(q_b3),
    .collision(col3)
  );

  heap_level_ram #(.LEVEL(3), .READ_LATENCY(1)) u_l3r (
    .clk(clk), .rst(rst), .init_req(init_req),
    .init_busy(busy3r),
    .data_a(data_a), .we_a(we_a), .addr_a(addr_a), .q_a(q_a3r),
    .data_b(data_b), .we_b(we_b), .addr_b(addr_b), .q_b(q_b3r),
    .collision(col3r)
  );

  heap_level_ram #(.LEVEL(0), .READ_LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .init_req(init_req),
    .init_busy(busy0),
    .data_a(data_a), .we_a(we_a), .addr_a(addr_a), .q_a(q_a0),
    .data_b(data_b), .we_b(we_b), .addr_b(addr_b), .q_b(q_b0),
    .collision(col0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset fill
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy3", 32'(busy3), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd1);
    chk("rst_col3", 32'(col3), 32'd0);
    chk("rst_qa3", q_a3, 32'hFFFF_FFFF);
    chk("rst_qa3r", q_a3r, 32'hFFFF_FFFF);
    c = 0;
    while (busy3 && c < 20) begin
      c++;
      if (c == 2) chk("l0_busy_end", 32'(busy0), 32'd0);
      step();
    end
    chk("busy_len", c, 8);
    chk("busy_len_r", 32'(busy3r), 32'd0);
    for (int a = 0; a < 8; a++) begin
      addr_a = 5'(a);
      #1;
      chk($sformatf("fill_rd%0d", a), q_a3, 32'hFFFF_FFFF);
    end

    // dual write, different addresses
    addr_a = 5'd2; data_a = 32'h11; we_a = 1'b1;
    addr_b = 5'd5; data_b = 32'h22; we_b = 1'b1;
    step();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("dual_qa", q_a3, 32'h11);
    chk("dual_qb", q_b3, 32'h22);
    chk("dual_col", 32'(col3), 32'd0);
    chk("rl1_old", q_a3r, 32'hFFFF_FFFF);
    chk("l0_win", q_a0, 32'h11);
    chk("l0_col", 32'(col0), 32'd1);
    step();
    chk("rl1_new", q_a3r, 32'h11);
    chk("l0_col_clr", 32'(col0), 32'd0);

    // same-address collision
    addr_a = 5'd4; data_a = 32'hAA; we_a = 1'b1;
    addr_b = 5'd4; data_b = 32'hBB; we_b = 1'b1;
    step();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("coll_qa", q_a3, 32'hAA);
    chk("coll_qb", q_b3, 32'hAA);
    chk("coll_flag", 32'(col3), 32'd1);
    step();
    chk("coll_one", 32'(col3), 32'd0);
    chk("coll_ram_r", q_b3r, 32'hAA);

    // read-first with registered read
    addr_a = 5'd3; data_a = 32'h05; we_a = 1'b1;
    step();
    data_a = 32'h07; addr_b = 5'd3;
    step();
    we_a = 1'b0;
    chk("rf_old", q_b3r, 32'h05);
    step();
    chk("rf_new", q_b3r, 32'h07);

    // mid-fill reset with writes during busy
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy", 32'(busy3), 32'd1);
    rst = 1'b1;
    addr_a = 5'd6; data_a = 32'h99; we_a = 1'b1;
    addr_b = 5'd6; data_b = 32'h77; we_b = 1'b1;
    step();
    rst = 1'b0;
    c = 0;
    while (busy3 && c < 20) begin
      c++;
      step();
    end
    we_a = 1'b0; we_b = 1'b0;
    chk("mid_len", c, 8);
    chk("mid_col", 32'(col3), 32'd0);
    for (int a = 0; a < 8; a++) begin
      addr_a = 5'(a);
      addr_b = 5'(7 - a);
      #1;
      chk($sformatf("mid_rda%0d", a), q_a3, 32'hFFFF_FFFF);
      chk($sformatf("mid_rdb%0d", a), q_b3, 32'hFFFF_FFFF);
    end

    // LEVEL=0 init request
    data_a = 32'h3C; we_a = 1'b1;
    step();
    we_a = 1'b0;
    chk("l0_wr", q_a0, 32'h3C);
    chk("l0_wr_b", q_b0, 32'h3C);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    chk("l0_ireq_busy", 32'(busy0), 32'd1);
    chk("l0_ireq_q", q_a0, 32'hFFFF_FFFF);
    data_a = 32'h55; we_a = 1'b1;
    step();
    we_a = 1'b0;
    chk("l0_ireq_done", 32'(busy0), 32'd0);
    chk("l0_ireq_qa", q_a0, 32'hFFFF_FFFF);
    chk("l0_ireq_qb", q_b0, 32'hFFFF_FFFF);
    chk("l3_ireq_busy", 32'(busy3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
